// File: rtl/gshare_spec_predictor_if.sv
// Front-end branch predictor bus: prediction request/response, execute-stage
// recovery and ROB commit/flush channels.
interface gshare_spec_predictor_if #(
    parameter int CKPT_DEPTH = 8
);
    localparam int CK_W = $clog2(CKPT_DEPTH);

    logic            pred_valid_i;
    logic [31:0]     pc_i;
    logic            pred_ready_o;
    logic            prediction_o;
    logic [31:0]     target_o;
    logic [CK_W-1:0] pred_tag_o;
    logic            recover_i;
    logic [CK_W-1:0] recover_tag_i;
    logic            recover_taken_i;
    logic            commit_i;
    logic [31:0]     commit_pc_i;
    logic            commit_taken_i;
    logic [31:0]     commit_target_i;
    logic            flush_i;

    modport master (
        output pred_valid_i, pc_i, recover_i, recover_tag_i, recover_taken_i,
               commit_i, commit_pc_i, commit_taken_i, commit_target_i, flush_i,
        input  pred_ready_o, prediction_o, target_o, pred_tag_o
    );

    modport slave (
        input  pred_valid_i, pc_i, recover_i, recover_tag_i, recover_taken_i,
               commit_i, commit_pc_i, commit_taken_i, commit_target_i, flush_i,
        output pred_ready_o, prediction_o, target_o, pred_tag_o
    );
endinterface

// File: rtl/gshare_spec_predictor.sv
// Gshare predictor with speculative GHR, per-branch history checkpoints for
// mispredict repair, and in-order training of the PHT/BTB at commit.
module gshare_spec_predictor #(
    parameter int PHT_ENTRIES = 1024,
    parameter int GHR_WIDTH   = 10,
    parameter int CTR_WIDTH   = 2,
    parameter int BTB_ENTRIES = 256,
    parameter int CKPT_DEPTH  = 8
) (
    input logic                    clk_i,
    input logic                    reset_i,
    gshare_spec_predictor_if.slave bus
);
    localparam int PHT_IW = $clog2(PHT_ENTRIES);
    localparam int BTB_IW = $clog2(BTB_ENTRIES);
    localparam int BTAG_W = 30 - BTB_IW;
    localparam int CK_W   = $clog2(CKPT_DEPTH);
    localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_WIDTH'((1 << (CTR_WIDTH-1)) - 1);
    localparam logic [CTR_WIDTH-1:0] CTR_MAX  = '1;

    typedef struct packed {
        logic [GHR_WIDTH-1:0] ghr;
        logic [PHT_IW-1:0]    pht_idx;
        logic                 pred;
    } ckpt_t;

    logic [CTR_WIDTH-1:0] r_pht     [PHT_ENTRIES];
    logic                 r_btb_vld [BTB_ENTRIES];
    logic [BTAG_W-1:0]    r_btb_tag [BTB_ENTRIES];
    logic [31:0]          r_btb_tgt [BTB_ENTRIES];
    ckpt_t                r_ckpt    [CKPT_DEPTH];
    logic [GHR_WIDTH-1:0] r_spec_ghr, r_arch_ghr;
    logic [CK_W-1:0]      r_head, r_tail;
    logic [CK_W:0]        r_count;

    // Prediction path: purely combinational on pc_i and current spec history
    logic [PHT_IW-1:0] w_ghr_ext, w_idx;
    logic [BTB_IW-1:0] w_bidx;
    logic [BTAG_W-1:0] w_btag;
    logic              w_hit, w_pred, w_fire;

    assign w_ghr_ext = PHT_IW'(r_spec_ghr);
    assign w_idx     = bus.pc_i[PHT_IW+1:2] ^ w_ghr_ext;
    assign w_bidx    = bus.pc_i[BTB_IW+1:2];
    assign w_btag    = bus.pc_i[31:BTB_IW+2];
    assign w_hit     = r_btb_vld[w_bidx] && (r_btb_tag[w_bidx] == w_btag);
    assign w_pred    = r_pht[w_idx][CTR_WIDTH-1] & w_hit;

    assign bus.prediction_o = w_pred;
    assign bus.target_o     = w_pred ? r_btb_tgt[w_bidx] : bus.pc_i + 32'd4;
    assign bus.pred_tag_o   = r_tail;
    assign bus.pred_ready_o = (r_count != (CK_W+1)'(CKPT_DEPTH));

    assign w_fire = bus.pred_valid_i & bus.pred_ready_o & ~bus.recover_i & ~bus.flush_i;

    // Commit path trains with the index captured at prediction time
    ckpt_t                w_head;
    logic                 w_commit;
    logic [CTR_WIDTH-1:0] w_ctr, w_ctr_nxt;
    logic [BTB_IW-1:0]    w_cbidx;
    logic [GHR_WIDTH-1:0] w_arch_nxt;
    logic [CK_W-1:0]      w_head_nxt;
    logic [CK_W:0]        w_rec_cnt;
    logic                 w_unused;

    assign w_head   = r_ckpt[r_head];
    assign w_commit = bus.commit_i && (r_count != '0);
    assign w_ctr    = r_pht[w_head.pht_idx];
    assign w_cbidx  = bus.commit_pc_i[BTB_IW+1:2];

    always_comb begin
        w_ctr_nxt = w_ctr;
        if (bus.commit_taken_i && (w_ctr != CTR_MAX))
            w_ctr_nxt = w_ctr + CTR_WIDTH'(1);
        else if (!bus.commit_taken_i && (w_ctr != '0))
            w_ctr_nxt = w_ctr - CTR_WIDTH'(1);
    end

    assign w_arch_nxt = w_commit ? {r_arch_ghr[GHR_WIDTH-2:0], bus.commit_taken_i} : r_arch_ghr;
    assign w_head_nxt = r_head + CK_W'(w_commit);
    // Entries head..recover_tag survive a recovery, inclusive
    assign w_rec_cnt  = {1'b0, bus.recover_tag_i - r_head} + (CK_W+1)'(1);
    assign w_unused   = ^{bus.commit_pc_i[1:0], w_head.pred};

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < PHT_ENTRIES; i++) r_pht[i] <= CTR_INIT;
            for (int i = 0; i < BTB_ENTRIES; i++) r_btb_vld[i] <= 1'b0;
            r_spec_ghr <= '0;
            r_arch_ghr <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else begin
            if (w_fire)
                r_ckpt[r_tail] <= '{ghr: r_spec_ghr, pht_idx: w_idx, pred: w_pred};

            if (w_commit) begin
                r_pht[w_head.pht_idx] <= w_ctr_nxt;
                if (bus.commit_taken_i) begin
                    r_btb_vld[w_cbidx] <= 1'b1;
                    r_btb_tag[w_cbidx] <= bus.commit_pc_i[31:BTB_IW+2];
                    r_btb_tgt[w_cbidx] <= bus.commit_target_i;
                end
            end
            r_arch_ghr <= w_arch_nxt;
            r_head     <= w_head_nxt;

            if (bus.flush_i) begin
                r_spec_ghr <= w_arch_nxt;
                r_tail     <= w_head_nxt;
                r_count    <= '0;
            end else if (bus.recover_i) begin
                r_spec_ghr <= {r_ckpt[bus.recover_tag_i].ghr[GHR_WIDTH-2:0], bus.recover_taken_i};
                r_tail     <= bus.recover_tag_i + CK_W'(1);
                r_count    <= w_rec_cnt - (CK_W+1)'(w_commit);
            end else begin
                if (w_fire) begin
                    r_spec_ghr <= {r_spec_ghr[GHR_WIDTH-2:0], w_pred};
                    r_tail     <= r_tail + CK_W'(1);
                end
                r_count <= r_count + (CK_W+1)'(w_fire) - (CK_W+1)'(w_commit);
            end
        end
    end

`ifdef ASSERTIONS
    always_ff @(posedge clk_i)
        if (!reset_i)
            assert (!(bus.commit_i && (r_count == '0)))
                else $error("commit with no outstanding checkpoint");
`endif
endmodule
